// File: rtl/pi_ctl_slew_limiter.sv
// Per-lane PI code slew limiter: moves each output code toward its target along the shortest
// circular path, at most max_step LSB per tick. Optional macro PI_SLEW_SATCNT_EN adds sat_cnt.
module pi_ctl_slew_limiter #(
  parameter int Npi   = 9,
  parameter int Nout  = 4,
  parameter int Nstep = 4,
  parameter int Ndiv  = 4
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic [Nout*Npi-1:0]   pi_ctl_tgt,
  input  logic                  en_slew,
  input  logic                  freeze,
  input  logic                  init,
  input  logic [Nstep-1:0]      max_step,
  input  logic [Ndiv-1:0]       ndiv_tick,
  output logic [Nout*Npi-1:0]   pi_ctl_out,
  output logic [Nout-1:0]       settled,
  output logic                  busy
`ifdef PI_SLEW_SATCNT_EN
  ,
  output logic [Nout*16-1:0]    sat_cnt
`endif
);

  localparam int W = Npi + 2;
  localparam logic [Npi-1:0] HALF = {1'b1, {(Npi-1){1'b0}}};

  typedef enum logic [1:0] {INIT, TRACK, HOLD} state_t;

  state_t              state_q, state_d;
  logic [Ndiv-1:0]     cnt_q, cnt_d;
  logic [Nout*Npi-1:0] out_q, out_d;
  logic [Nout*Npi-1:0] slew_out;
  logic [Nout-1:0]     over_step;
  logic                tick;

  assign tick = (cnt_q == ndiv_tick);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Signed circular distance, widened so clamping and negation never overflow.
  always_comb begin
    logic [Npi-1:0]        diff;
    logic signed [W-1:0]   diff_ext;
    logic signed [W-1:0]   lim;
    logic signed [W-1:0]   step;
    logic                  over_pos;
    slew_out  = '0;
    over_step = '0;
    lim       = signed'({{(W-Nstep){1'b0}}, max_step});
    for (int i = 0; i < Nout; i++) begin
      diff = pi_ctl_tgt[i*Npi +: Npi] - out_q[i*Npi +: Npi];
      if (diff == HALF)
        diff_ext = signed'({2'b00, diff});
      else
        diff_ext = signed'({{2{diff[Npi-1]}}, diff});
      over_pos     = (diff_ext > lim);
      over_step[i] = over_pos || (diff_ext < -lim);
      if (over_step[i])
        step = over_pos ? lim : -lim;
      else
        step = diff_ext;
      slew_out[i*Npi +: Npi] = out_q[i*Npi +: Npi] + step[Npi-1:0];
    end
  end

  // init loads the target immediately and wins over freeze from any state.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    if (init) begin
      state_d = INIT;
      out_d   = pi_ctl_tgt;
    end else begin
      case (state_q)
        INIT: begin
          out_d   = pi_ctl_tgt;
          state_d = TRACK;
        end
        TRACK: begin
          if (freeze)
            state_d = HOLD;
          else if (!en_slew)
            out_d = pi_ctl_tgt;
          else if (tick)
            out_d = slew_out;
        end
        HOLD: begin
          if (!freeze)
            state_d = TRACK;
        end
        default: state_d = INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= INIT;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign pi_ctl_out = out_q;

  always_comb begin
    for (int i = 0; i < Nout; i++)
      settled[i] = (state_q != INIT) && (out_q[i*Npi +: Npi] == pi_ctl_tgt[i*Npi +: Npi]);
  end

  assign busy = (state_q == TRACK) && !(&settled);

`ifdef PI_SLEW_SATCNT_EN
  logic [Nout*16-1:0] sat_q, sat_d;

  // Counts slew-limited ticks per lane, saturating.
  always_comb begin
    sat_d = sat_q;
    if (init) begin
      sat_d = '0;
    end else if (state_q == TRACK && !freeze && en_slew && tick) begin
      for (int i = 0; i < Nout; i++)
        if (over_step[i] && sat_q[i*16 +: 16] != 16'hFFFF)
          sat_d[i*16 +: 16] = sat_q[i*16 +: 16] + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)
      sat_q <= '0;
    else
      sat_q <= sat_d;
  end

  assign sat_cnt = sat_q;
`endif

endmodule

// File: doc/pi_ctl_slew_limiter.md
Name: pi_ctl_slew_limiter

Overview:
- Sits directly downstream of the CDR phase-interpolator code path and upstream of the analog PI control inputs.
- Takes per-lane target PI codes (CDR output plus offset, before scaling) and moves a registered output code toward each target by at most max_step LSB per update tick.
- Code space is circular modulo 2^Npi. Every move takes the shortest path around the circle, so large target jumps never produce glitchy phase steps.
- Update rate is set by a programmable tick divider. Freeze and re-initialise are controlled over JTAG.

Parameters:
- Npi, 9, PI code width in bits.
- Nout, 4, number of PI lanes.
- Nstep, 4, width of max_step.
- Ndiv, 4, width of tick divider setting.

Ports:
- clk  input  1  core clock (clk_adc domain).
- rstb  input  1  asynchronous active-low reset.
- pi_ctl_tgt  input  [Npi-1:0] x Nout  target code per lane.
- en_slew  input  1  1: limit slew; 0: bypass (output follows target, registered).
- freeze  input  1  hold all outputs; the tick counter keeps running.
- init  input  1  one-cycle pulse: load output = target on all lanes.
- max_step  input  Nstep  max LSB change per tick; 0 = hold.
- ndiv_tick  input  Ndiv  tick period = ndiv_tick+1 cycles.
- pi_ctl_out  output  [Npi-1:0] x Nout  limited PI code per lane.
- settled  output  Nout  lane output equals target.
- busy  output  1  OR of ~settled while in TRACK.

Behaviour:
- Reset values: pi_ctl_out = 0, settled = 0, busy = 0, tick counter = 0, FSM = INIT.
- Tick counter:
  - Counts 0..ndiv_tick, then wraps to 0.
  - tick asserts for one cycle when the count equals ndiv_tick. ndiv_tick = 0 means tick every cycle.
  - A change of ndiv_tick mid-count takes effect at the next compare. If count > new value, the counter wraps through 2^Ndiv-1.
- FSM states: INIT, TRACK, HOLD.
  - INIT: pi_ctl_out <= pi_ctl_tgt on the next edge; go to TRACK unconditionally.
  - TRACK: on tick, each lane updates; go to HOLD if freeze=1.
  - HOLD: outputs constant; return to TRACK when freeze=0.
  - init=1 in any state forces INIT next cycle; init has priority over freeze.
- Lane arithmetic (TRACK, tick):
  - diff = (tgt - out) mod 2^Npi, interpreted as signed Npi-bit.
  - If diff = -2^(Npi-1) (exact half-circle), treat it as +2^(Npi-1), i.e. step up.
  - step = clamp(diff, -max_step, +max_step).
  - out <= (out + step) mod 2^Npi, so the code wraps 2^Npi-1 to 0 and vice versa.
  - The arithmetic carries enough bits that clamping never overflows.
- en_slew=0:
  - Every cycle, out <= tgt; FSM still honours freeze and init.
  - Reads as one cycle of latency when not frozen.
- Latency:
  - pi_ctl_out changes on the clock edge at the end of the tick cycle.
  - settled and busy are combinational from the registered pi_ctl_out and the current target.
- Target change mid-slew: the new target is used on the next tick; no restart.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); the first post-reset cycle is INIT.

Optional Feature:
- Macro: PI_SLEW_SATCNT_EN.
- When defined:
  - Adds output sat_cnt, 16 bits x Nout.
  - Per lane, counts ticks in TRACK where |diff| > max_step.
  - Saturates at 16'hFFFF; cleared by rstb and by init.
- When undefined: no port and no counter logic.

Test Plan:
- Reset release, tgt[0]=100, max_step=4, ndiv_tick=0, en_slew=1:
  - INIT loads out=100, settled[0]=1.
  - tgt→120: out steps 104, 108, ... 120 on consecutive cycles, then settled[0]=1 and busy=0.
- Wrap path, Npi=9, out=510, tgt=3, max_step=2:
  - Sequence 0, 2, 3; never decreases; never passes through 256.
- Half-circle, out=0, tgt=256, max_step=8:
  - First tick gives out=8 (positive direction).
- ndiv_tick=3, max_step=1, out=10, tgt=12:
  - out=11 after 4 cycles, 12 after 8.
- freeze=1 mid-slew holds out for 20 cycles. Asserting init during freeze gives out=tgt next cycle and the FSM in TRACK.
- With PI_SLEW_SATCNT_EN, out=0, tgt=40, max_step=8:
  - sat_cnt[0]=4 after settle; init clears it to 0.
